// File: rtl/mprj2_logic_monitor.sv
// mprj2_logic_monitor: debounces the domain-2 tie-high and sequences isolation and reset release.
// Ports:
//   wb_clk_i, wb_rst_i  management clock, synchronous active-high reset
//   mprj2_vdd_logic1    async tie-high level from domain 2 (1 = vccd2 present)
//   force_iso_i         management override, isolates and resets domain 2
//   iso_en_n_o          0 = domain-2 signals isolated, 1 = pass-through
//   user2_rst_o         active-high reset into domain-2 logic
//   power_good_o        1 only when fully powered up
//   state_o             FSM state (0 OFF, 1 DEBOUNCE, 2 RELEASE, 3 ON)
//   loss_count_o        saturating count of power-loss events
//   irq_o, irq_clr_i    sticky loss interrupt and its clear
// Optional feature: MPRJ2_LOSS_IRQ_EN enables the loss interrupt flop; otherwise irq_o is 0.
module mprj2_logic_monitor #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int RESET_HOLD_CYCLES = 8,
    parameter int LOSS_CNT_W        = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  mprj2_vdd_logic1,
    input  logic                  force_iso_i,
    output logic                  iso_en_n_o,
    output logic                  user2_rst_o,
    output logic                  power_good_o,
    output logic [1:0]            state_o,
    output logic [LOSS_CNT_W-1:0] loss_count_o,
    output logic                  irq_o,
    input  logic                  irq_clr_i
);
    localparam logic [1:0] OFF      = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] RELEASE  = 2'd2;
    localparam logic [1:0] ON       = 2'd3;
    localparam int CMAX  = (DEBOUNCE_CYCLES > RESET_HOLD_CYCLES) ? DEBOUNCE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
    logic             s1, vdd_s;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             loss;
    // Power loss only counts once isolation has been released and the override is not the cause.
    assign loss = !force_iso_i && !vdd_s && state[1];
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1           <= 1'b0;
            vdd_s        <= 1'b0;
            state        <= OFF;
            cnt          <= '0;
            loss_count_o <= '0;
        end else begin
            s1    <= mprj2_vdd_logic1;
            vdd_s <= s1;
            if (force_iso_i || !vdd_s) begin
                state <= OFF;
                cnt   <= '0;
            end else begin
                case (state)
                    OFF: begin
                        state <= DEBOUNCE;
                        cnt   <= '0;
                    end
                    DEBOUNCE: begin
                        state <= (cnt == DEB_LAST) ? RELEASE : DEBOUNCE;
                        cnt   <= (cnt == DEB_LAST) ? '0 : cnt + 1'b1;
                    end
                    RELEASE: begin
                        state <= (cnt == HOLD_LAST) ? ON : RELEASE;
                        cnt   <= (cnt == HOLD_LAST) ? '0 : cnt + 1'b1;
                    end
                    default: begin
                        state <= ON;
                        cnt   <= '0;
                    end
                endcase
            end
            if (loss && loss_count_o != '1)
                loss_count_o <= loss_count_o + 1'b1;
        end
    end
    assign iso_en_n_o   = state[1];
    assign user2_rst_o  = state != ON;
    assign power_good_o = state == ON;
    assign state_o      = state;
`ifdef MPRJ2_LOSS_IRQ_EN
    logic irq;
    // A loss in the same cycle as a clear wins, so no event is silently dropped.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            irq <= 1'b0;
        else
            irq <= loss || (irq && !irq_clr_i);
    end
    assign irq_o = irq;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr_i;
    assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_mprj2_logic_monitor.sv
// tb_mprj2_logic_monitor: randomized and directed checks against a run-length power model.
module tb_mprj2_logic_monitor;
    localparam int D = 16;
    localparam int H = 8;
    logic clk = 1'b0;
    logic rst = 1'b1, vdd = 1'b0, force_iso = 1'b0, clr = 1'b0;
    logic iso, u2rst, pg, irq, iso2, u2rst2, pg2, irq2;
    logic [1:0] st, st2, lc2_o;
    logic [7:0] lc;
    int n_assert = 0, n_fail = 0;
    int r = 0, lc8 = 0, lc2 = 0;
    bit p1 = 0, p2 = 0, irq_m = 0, c, loss;
    always #5 clk = ~clk;
    mprj2_logic_monitor u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .mprj2_vdd_logic1(vdd), .force_iso_i(force_iso),
        .iso_en_n_o(iso), .user2_rst_o(u2rst), .power_good_o(pg), .state_o(st),
        .loss_count_o(lc), .irq_o(irq), .irq_clr_i(clr)
    );
    mprj2_logic_monitor #(.LOSS_CNT_W(2)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .mprj2_vdd_logic1(vdd), .force_iso_i(force_iso),
        .iso_en_n_o(iso2), .user2_rst_o(u2rst2), .power_good_o(pg2), .state_o(st2),
        .loss_count_o(lc2_o), .irq_o(irq2), .irq_clr_i(clr)
    );
    wire [15:0] vec = {iso, u2rst, pg, st, lc, irq, lc2_o};
    // r = number of consecutive edges with synced power present and no override.
    always @(posedge clk) begin
        if (rst) begin
            r = 0; p1 = 0; p2 = 0; lc8 = 0; lc2 = 0; irq_m = 0;
        end else begin
            c    = p2 && !force_iso;
            loss = !force_iso && !p2 && r > D;
            if (loss) begin
                lc8 = (lc8 < 255) ? lc8 + 1 : 255;
                lc2 = (lc2 < 3) ? lc2 + 1 : 3;
            end
`ifdef MPRJ2_LOSS_IRQ_EN
            irq_m = loss ? 1'b1 : (clr ? 1'b0 : irq_m);
`endif
            r  = c ? ((r < 100) ? r + 1 : r) : 0;
            p2 = p1;
            p1 = vdd;
        end
    end
    function automatic logic [15:0] expv();
        logic [1:0] s;
        logic [7:0] l8;
        logic [1:0] l2;
        s  = (r == 0) ? 2'd0 : (r <= D) ? 2'd1 : (r <= D + H) ? 2'd2 : 2'd3;
        l8 = lc8[7:0];
        l2 = lc2[1:0];
        return {s >= 2'd2, s != 2'd3, s == 2'd3, s, l8, irq_m, l2};
    endfunction
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if (vec !== 16'h4000) begin n_fail++; $display("FAIL reset_state got %h want %h", vec, 16'h4000); end
        n_assert++;
        if (vec !== expv()) begin n_fail++; $display("FAIL reset_model got %h want %h", vec, expv()); end
        rst = 1'b0;
    endtask
    task automatic test_power_up();
        int iso_at = 0, pg_at = 0, deb_at = 0;
        vdd = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            n_assert++;
            if (vec !== expv()) begin n_fail++; $display("FAIL power_up e%0d got %h want %h", e, vec, expv()); end
            if (st == 2'd1 && deb_at == 0) deb_at = e;
            if (iso && iso_at == 0) iso_at = e;
            if (pg && pg_at == 0) pg_at = e;
        end
        n_assert++;
        if (deb_at != 3) begin n_fail++; $display("FAIL debounce_edge got %0d want 3", deb_at); end
        n_assert++;
        if (iso_at != 3 + D) begin n_fail++; $display("FAIL iso_edge got %0d want %0d", iso_at, 3 + D); end
        n_assert++;
        if (pg_at != 3 + D + H) begin n_fail++; $display("FAIL pg_edge got %0d want %0d", pg_at, 3 + D + H); end
        n_assert++;
        if (st !== 2'd3 || u2rst !== 1'b0) begin n_fail++; $display("FAIL on_state got st=%0d rst=%b want st=3 rst=0", st, u2rst); end
    endtask
    task automatic test_short_pulse();
        bit saw_iso = 0;
        rst = 1'b1; vdd = 1'b0;
        @(negedge clk);
        rst = 1'b0; vdd = 1'b1;
        for (int e = 0; e < 20; e++) begin
            if (e == 10) vdd = 1'b0;
            @(negedge clk);
            n_assert++;
            if (vec !== expv()) begin n_fail++; $display("FAIL short_pulse e%0d got %h want %h", e, vec, expv()); end
            saw_iso |= iso;
        end
        n_assert++;
        if (saw_iso || st !== 2'd0 || lc !== 8'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL short_pulse_end got iso_seen=%b st=%0d lc=%0d irq=%b want 0 0 0 0", saw_iso, st, lc, irq);
        end
    endtask
    task automatic test_loss_in_on();
        int off_at = 0;
        vdd = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            n_assert++;
            if (vec !== expv()) begin n_fail++; $display("FAIL loss_up e%0d got %h want %h", e, vec, expv()); end
        end
        vdd = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            n_assert++;
            if (vec !== expv()) begin n_fail++; $display("FAIL loss_down e%0d got %h want %h", e, vec, expv()); end
            if (!iso && u2rst && off_at == 0) off_at = e;
        end
        n_assert++;
        if (off_at != 3) begin n_fail++; $display("FAIL loss_edge got %0d want 3", off_at); end
        n_assert++;
        if (lc !== 8'd1) begin n_fail++; $display("FAIL loss_count got %0d want 1", lc); end
`ifdef MPRJ2_LOSS_IRQ_EN
        n_assert++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL loss_irq got %b want 1", irq); end
`else
        n_assert++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL loss_irq got %b want 0", irq); end
`endif
    endtask
    task automatic test_force();
        int iso_at = 0, pg_at = 0;
        vdd = 1'b1;
        repeat (30) @(negedge clk);
        force_iso = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            n_assert++;
            if (vec !== expv() || st !== 2'd0) begin n_fail++; $display("FAIL force_hold e%0d got %h want %h", e, vec, expv()); end
        end
        n_assert++;
        if (lc !== 8'd1) begin n_fail++; $display("FAIL force_no_loss got %0d want 1", lc); end
        force_iso = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            n_assert++;
            if (vec !== expv()) begin n_fail++; $display("FAIL force_release e%0d got %h want %h", e, vec, expv()); end
            if (iso && iso_at == 0) iso_at = e;
            if (pg && pg_at == 0) pg_at = e;
        end
        n_assert++;
        if (iso_at != D + 1 || pg_at != D + H + 1) begin
            n_fail++; $display("FAIL force_relatch got iso=%0d pg=%0d want %0d %0d", iso_at, pg_at, D + 1, D + H + 1);
        end
    endtask
    task automatic test_saturation();
        int lc_before = lc8;
        for (int k = 0; k < 5; k++) begin
            for (int e = 0; e < 36; e++) begin
                vdd = (e < 30);
                @(negedge clk);
                n_assert++;
                if (vec !== expv()) begin n_fail++; $display("FAIL saturate k%0d e%0d got %h want %h", k, e, vec, expv()); end
            end
        end
        n_assert++;
        if (lc2_o !== 2'd3) begin n_fail++; $display("FAIL sat_count2 got %0d want 3", lc2_o); end
        n_assert++;
        if (lc !== 8'(lc_before + 5)) begin n_fail++; $display("FAIL sat_count8 got %0d want %0d", lc, lc_before + 5); end
        vdd = 1'b1;
        repeat (8) @(negedge clk);
        n_assert++;
        if (st !== 2'd1) begin n_fail++; $display("FAIL mid_debounce got %0d want 1", st); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_assert++;
        if (st !== 2'd0 || lc !== 8'd0 || lc2_o !== 2'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got st=%0d lc=%0d lc2=%0d irq=%b want 0 0 0 0", st, lc, lc2_o, irq);
        end
    endtask
    task automatic test_irq_same_cycle();
        vdd = 1'b1;
        repeat (32) @(negedge clk);
        vdd = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        n_assert++;
        if (vec !== expv()) begin n_fail++; $display("FAIL irq_set_clr got %h want %h", vec, expv()); end
`ifdef MPRJ2_LOSS_IRQ_EN
        n_assert++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got %b want 1", irq); end
`endif
        @(negedge clk);
        clr = 1'b0;
        n_assert++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
    endtask
    task automatic test_random();
        int hold = 0, fhold = 0;
        for (int e = 0; e < 3000; e++) begin
            if (hold == 0) begin
                vdd = ($urandom_range(0, 2) != 0);
                hold = $urandom_range(1, 45);
            end
            if (fhold == 0) begin
                force_iso = ($urandom_range(0, 9) == 0);
                fhold = force_iso ? $urandom_range(1, 6) : $urandom_range(5, 60);
            end
            hold--; fhold--;
            clr = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            n_assert++;
            if (vec !== expv()) begin n_fail++; $display("FAIL random e%0d got %h want %h", e, vec, expv()); end
        end
        rst = 1'b0; force_iso = 1'b0; clr = 1'b0;
    endtask
    initial begin
        test_reset();
        test_power_up();
        test_short_pulse();
        test_loss_in_on();
        test_force();
        test_saturation();
        test_irq_same_cycle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
